// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding, RV32I
// load/store funct3 codes, byte-enable patterns and the access legality
// helpers used when an EX-stage memory op is offered.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  // RV32I funct3 for loads/stores; bits [1:0] encode the access size.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte-enable patterns for lane 0; shifted up by addr[1:0] at use.
  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Unsigned variants exist only for loads.
  function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic bad;
    case (f3[1:0])
      2'b00:   bad = 1'b0;
      2'b01:   bad = addr_lo[0];
      default: bad = (addr_lo != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
//   bus_req/bus_we/bus_addr/bus_be/bus_wdata : request, held until bus_ack
//   bus_ack/bus_rdata                        : completion and read word
interface lsu_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Lane alignment for the load/store unit (purely combinational).
//   funct3, addr_lo : access size/sign and byte offset within the word
//   wdata -> wdata_rep, be : store data replicated across lanes, byte enables
//   rdata -> rdata_ext     : load lane extracted and sign/zero-extended
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;
  logic        sign_ext;

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    be        = BE_NONE;
    wdata_rep = wdata;
    rdata_ext = '0;
    shifted   = rdata >> {addr_lo, 3'b000};
    sign_ext  = ~funct3[2];
    case (funct3[1:0])
      2'b00: begin
        be        = BE_BYTE << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        be        = BE_HALF << addr_lo;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        // Word accesses are aligned, so the shift is zero here.
        be        = BE_WORD;
        rdata_ext = shifted;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one EX-stage memory op at a time, runs it
// on the data-memory bus with a wait-cycle timeout, and returns load data
// to writeback. Illegal/misaligned ops and timeouts raise a one-cycle lsu_err.
//   clk, rst_n      : clock; synchronous reset, asserted high
//   ex_*            : memory op from EX (valid, read/write, funct3, addr, data, rd)
//   lsu_stall       : freeze upstream while an op is accepted or in flight
//   wb_valid/rd/rdata : load writeback, one cycle in DONE
//   lsu_err         : one-cycle error pulse
//   bus             : data-memory bus master
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_memread,
  input  logic        ex_memwrite,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        lsu_stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_rdata,
  output logic        lsu_err,
  lsu_if.master       bus
);

  localparam int              CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             store_q, store_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [4:0]       rd_q, rd_d;
  logic             err_q, err_d;

  logic        ex_op, ex_bad, accept, in_req, ld_done;
  logic [3:0]  be_lane;
  logic [31:0] wdata_lane, rdata_lane;

  // Alignment works off the latched op so bus outputs stay stable in REQ.
  lsu_align u_align (
    .funct3    (funct3_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (rdata_q),
    .be        (be_lane),
    .wdata_rep (wdata_lane),
    .rdata_ext (rdata_lane)
  );

  assign ex_op  = ex_valid & (ex_memread | ex_memwrite);
  assign ex_bad = (ex_memread & ex_memwrite)
                | ~funct3_legal(ex_memwrite, ex_funct3)
                | misaligned(ex_funct3, ex_addr[1:0]);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    store_d  = store_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rd_d     = rd_q;
    err_d    = 1'b0;
    accept   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_op) begin
          if (ex_bad) begin
            err_d = 1'b1;
          end else begin
            accept   = 1'b1;
            store_d  = ex_memwrite;
            funct3_d = ex_funct3;
            addr_d   = ex_addr;
            wdata_d  = ex_wdata;
            rd_d     = ex_rd;
            cnt_d    = '0;
            state_d  = REQ;
          end
        end
      end
      REQ: begin
        // An ack on the last allowed cycle still completes the access.
        if (bus.bus_ack) begin
          rdata_d = bus.bus_rdata;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      store_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rd_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      store_q  <= store_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
    end
  end

  assign in_req  = (state_q == REQ);
  assign ld_done = (state_q == DONE) & ~store_q;

  assign lsu_stall = in_req | accept;
  assign lsu_err   = err_q;
  assign wb_valid  = ld_done;
  assign wb_rd     = ld_done ? rd_q : '0;
  assign wb_rdata  = ld_done ? rdata_lane : '0;

  // Bus outputs are forced to zero whenever no request is outstanding.
  assign bus.bus_req   = in_req;
  assign bus.bus_we    = in_req & store_q;
  assign bus.bus_addr  = in_req ? {addr_q[31:2], 2'b00} : '0;
  assign bus.bus_be    = in_req ? be_lane : BE_NONE;
  assign bus.bus_wdata = in_req ? wdata_lane : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios followed by
// randomized loads/stores against a byte-addressed reference memory.
module tb_load_store_unit;

  localparam int MAX_WAIT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_memread = 1'b0;
  logic        ex_memwrite = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic [31:0] ex_addr = '0;
  logic [31:0] ex_wdata = '0;
  logic [4:0]  ex_rd = '0;
  logic        lsu_stall, wb_valid, lsu_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_rdata;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // 64-byte memory window, aliased over the whole address space.
  logic [7:0] dut_mem [64];
  logic [7:0] ref_mem [64];

  lsu_if bus_if ();

  load_store_unit #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_valid    (ex_valid),
    .ex_memread  (ex_memread),
    .ex_memwrite (ex_memwrite),
    .ex_funct3   (ex_funct3),
    .ex_addr     (ex_addr),
    .ex_wdata    (ex_wdata),
    .ex_rd       (ex_rd),
    .lsu_stall   (lsu_stall),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_rdata    (wb_rdata),
    .lsu_err     (lsu_err),
    .bus         (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int op_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit op_legal(input bit ld, input bit st, input logic [2:0] f3,
                                  input logic [31:0] a);
    bit f3_ok;
    if (ld == st) return 1'b0;
    if (ld) f3_ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    else    f3_ok = (f3 inside {3'd0, 3'd1, 3'd2});
    return f3_ok && ((a % op_size(f3)) == 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    longint unsigned v = 0;
    int sz = op_size(f3);
    for (int i = 0; i < sz; i++) v |= longint'(ref_mem[int'(a[5:0]) + i]) << (8 * i);
    if (!f3[2] && sz < 4 && v[8*sz-1]) v |= ~((64'd1 << (8 * sz)) - 64'd1);
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] be = '0;
    for (int i = 0; i < op_size(f3); i++) be[int'(a[1:0]) + i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] ref_bus_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (op_size(f3))
      1:       return {4{wd[7:0]}};
      2:       return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] word_of(input bit use_dut, input logic [31:0] a);
    int idx = int'(a[5:2]) * 4;
    if (use_dut) return {dut_mem[idx+3], dut_mem[idx+2], dut_mem[idx+1], dut_mem[idx]};
    return {ref_mem[idx+3], ref_mem[idx+2], ref_mem[idx+1], ref_mem[idx]};
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    int idx = int'(a[5:2]) * 4;
    for (int i = 0; i < 4; i++) begin
      dut_mem[idx+i] = w[8*i +: 8];
      ref_mem[idx+i] = w[8*i +: 8];
    end
  endtask

  // One complete op: offer it, act as memory (ack after ack_delay REQ cycles,
  // or never if negative), and check every cycle until the unit is idle again.
  task automatic run_op(input string tag, input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] rd, input int ack_delay);
    bit          legal, acked;
    int          cyc, widx;
    logic [31:0] exp_rd;
    legal  = op_legal(ld, st, f3, addr);
    exp_rd = ref_load(f3, addr);
    @(negedge clk);
    ex_valid = 1'b1; ex_memread = ld; ex_memwrite = st; ex_funct3 = f3;
    ex_addr = addr; ex_wdata = wd; ex_rd = rd;
    #1;
    check({tag, "/idle_req"}, 32'(bus_if.bus_req), 32'd0);
    if (legal) check({tag, "/accept_stall"}, 32'(lsu_stall), 32'd1);
    if (!legal) begin
      @(negedge clk);
      ex_valid = 1'b0;
      #1;
      check({tag, "/err_pulse"}, 32'(lsu_err), 32'd1);
      check({tag, "/err_no_req"}, 32'(bus_if.bus_req), 32'd0);
      check({tag, "/err_no_stall"}, 32'(lsu_stall), 32'd0);
      check({tag, "/err_no_wb"}, 32'(wb_valid), 32'd0);
      @(negedge clk);
      #1;
      check({tag, "/err_one_cycle"}, 32'(lsu_err), 32'd0);
      check({tag, "/err_still_no_req"}, 32'(bus_if.bus_req), 32'd0);
      return;
    end
    acked = 1'b0;
    cyc   = 0;
    while (!acked && cyc < MAX_WAIT) begin
      @(negedge clk);
      // A different op offered while busy must be ignored.
      ex_valid = 1'b1; ex_memread = 1'b1; ex_memwrite = 1'b0; ex_funct3 = 3'b010;
      ex_addr = $urandom & 32'hFFFF_FFFC; ex_wdata = $urandom; ex_rd = 5'($urandom);
      acked = (cyc == ack_delay);
      bus_if.bus_ack   = acked;
      bus_if.bus_rdata = acked ? word_of(1'b1, addr) : $urandom;
      #1;
      check({tag, "/req"}, 32'(bus_if.bus_req), 32'd1);
      check({tag, "/we"}, 32'(bus_if.bus_we), 32'(st));
      check({tag, "/addr"}, bus_if.bus_addr, {addr[31:2], 2'b00});
      check({tag, "/be"}, 32'(bus_if.bus_be), 32'(ref_be(f3, addr)));
      if (st) check({tag, "/wdata"}, bus_if.bus_wdata, ref_bus_wdata(f3, wd));
      check({tag, "/req_stall"}, 32'(lsu_stall), 32'd1);
      check({tag, "/req_no_err"}, 32'(lsu_err), 32'd0);
      check({tag, "/req_no_wb"}, 32'(wb_valid), 32'd0);
      if (acked && st) begin
        widx = int'(addr[5:2]) * 4;
        for (int l = 0; l < 4; l++)
          if (bus_if.bus_be[l]) dut_mem[widx+l] = bus_if.bus_wdata[8*l +: 8];
        for (int i = 0; i < op_size(f3); i++) ref_mem[int'(addr[5:0]) + i] = wd[8*i +: 8];
      end
      cyc++;
    end
    @(negedge clk);
    ex_valid = 1'b0;
    bus_if.bus_ack = 1'b0;
    #1;
    check({tag, "/end_req"}, 32'(bus_if.bus_req), 32'd0);
    check({tag, "/end_stall"}, 32'(lsu_stall), 32'd0);
    if (acked) begin
      check({tag, "/done_no_err"}, 32'(lsu_err), 32'd0);
      check({tag, "/wb_valid"}, 32'(wb_valid), 32'(ld));
      if (ld) begin
        check({tag, "/wb_rd"}, 32'(wb_rd), 32'(rd));
        check({tag, "/wb_rdata"}, wb_rdata, exp_rd);
      end
    end else begin
      check({tag, "/timeout_err"}, 32'(lsu_err), 32'd1);
      check({tag, "/timeout_no_wb"}, 32'(wb_valid), 32'd0);
    end
    @(negedge clk);
    #1;
    check({tag, "/idle_wb"}, 32'(wb_valid), 32'd0);
    check({tag, "/idle_err"}, 32'(lsu_err), 32'd0);
    check({tag, "/idle_req2"}, 32'(bus_if.bus_req), 32'd0);
    if (st && acked) check({tag, "/mem_word"}, word_of(1'b1, addr), word_of(1'b0, addr));
  endtask

  initial begin
    bit          ld;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [7:0]  b;

    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = '0;
    for (int i = 0; i < 64; i++) begin
      b = 8'($urandom);
      dut_mem[i] = b;
      ref_mem[i] = b;
    end

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("rst/bus_req", 32'(bus_if.bus_req), 32'd0);
    check("rst/bus_we", 32'(bus_if.bus_we), 32'd0);
    check("rst/bus_be", 32'(bus_if.bus_be), 32'd0);
    check("rst/bus_addr", bus_if.bus_addr, 32'd0);
    check("rst/bus_wdata", bus_if.bus_wdata, 32'd0);
    check("rst/wb_valid", 32'(wb_valid), 32'd0);
    check("rst/wb_rd", 32'(wb_rd), 32'd0);
    check("rst/wb_rdata", wb_rdata, 32'd0);
    check("rst/lsu_err", 32'(lsu_err), 32'd0);
    check("rst/lsu_stall", 32'(lsu_stall), 32'd0);
    rst_n = 1'b0;

    // Directed scenarios.
    preload(32'h100, 32'hDEAD_BEEF);
    run_op("lw_100", 1, 0, 3'b010, 32'h100, 32'h0, 5'd7, 3);
    check("lw_100/literal", word_of(1'b0, 32'h100), 32'hDEAD_BEEF);
    preload(32'h100, 32'h80FF_0000);
    run_op("lb_103", 1, 0, 3'b000, 32'h103, 32'h0, 5'd9, 1);
    check("lb_103/literal", ref_load(3'b000, 32'h103), 32'hFFFF_FF80);
    run_op("lbu_103", 1, 0, 3'b100, 32'h103, 32'h0, 5'd10, 0);
    run_op("sh_202", 0, 1, 3'b001, 32'h202, 32'h1234_ABCD, 5'd3, 2);
    run_op("lw_101_mis", 1, 0, 3'b010, 32'h101, 32'h0, 5'd4, 0);
    run_op("lh_105_mis", 1, 0, 3'b001, 32'h105, 32'h0, 5'd4, 0);
    run_op("both_rw", 1, 1, 3'b010, 32'h108, 32'h0, 5'd4, 0);
    run_op("ld_f3_011", 1, 0, 3'b011, 32'h108, 32'h0, 5'd4, 0);
    run_op("st_f3_100", 0, 1, 3'b100, 32'h108, 32'h0, 5'd4, 0);
    run_op("timeout", 1, 0, 3'b010, 32'h104, 32'h0, 5'd5, -1);
    run_op("lh_rd0", 1, 0, 3'b001, 32'h10E, 32'h0, 5'd0, 1);

    // Ack while idle must have no effect.
    @(negedge clk);
    bus_if.bus_ack = 1'b1;
    bus_if.bus_rdata = $urandom;
    @(negedge clk);
    bus_if.bus_ack = 1'b0;
    #1;
    check("stray_ack/wb", 32'(wb_valid), 32'd0);
    check("stray_ack/req", 32'(bus_if.bus_req), 32'd0);
    check("stray_ack/err", 32'(lsu_err), 32'd0);

    // Reset in the second REQ cycle discards the op.
    @(negedge clk);
    ex_valid = 1'b1; ex_memread = 1'b1; ex_memwrite = 1'b0; ex_funct3 = 3'b010;
    ex_addr = 32'h110; ex_rd = 5'd12;
    @(negedge clk);
    ex_valid = 1'b0;
    #1;
    check("mid_rst/req_c0", 32'(bus_if.bus_req), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rst/req_c1", 32'(bus_if.bus_req), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst/req_dropped", 32'(bus_if.bus_req), 32'd0);
    check("mid_rst/no_wb", 32'(wb_valid), 32'd0);
    check("mid_rst/no_err", 32'(lsu_err), 32'd0);
    @(negedge clk);
    #1;
    check("mid_rst/no_wb2", 32'(wb_valid), 32'd0);
    check("mid_rst/no_err2", 32'(lsu_err), 32'd0);
    run_op("after_rst", 1, 0, 3'b010, 32'h110, 32'h0, 5'd12, 0);

    // Randomized traffic over the shared memory window.
    for (int n = 0; n < 60; n++) begin
      ld = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom);
      else if (ld) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end else f3 = 3'($urandom_range(0, 2));
      addr = 32'h100 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'(op_size(f3) - 1);
      run_op($sformatf("rnd%0d", n), ld, !ld, f3, addr, $urandom, 5'($urandom),
             $urandom_range(0, 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 16: cycles in REQ without bus_ack before abort.
REQ-002 SHALL have port clk, input, 1: sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous and active-high (asserted = 1).
REQ-004 SHALL have port ex_valid, input, 1: EX-stage memory op present this cycle.
REQ-005 SHALL have ports ex_memread and ex_memwrite, input, 1 each: load / store request.
REQ-006 SHALL have port ex_funct3, input, 3: access size/sign (RV32I encoding).
REQ-007 SHALL have ports ex_addr and ex_wdata, input, 32 each: ALU-result byte address, store data (rs2).
REQ-008 SHALL have port ex_rd, input, 5: load destination register.
REQ-009 SHALL have port lsu_stall, output, 1: freeze PC and pipeline registers upstream.
REQ-010 SHALL have ports wb_valid (1), wb_rd (5), wb_rdata (32), output: load writeback.
REQ-011 SHALL have port lsu_err, output, 1: one-cycle pulse, illegal, misaligned or timed-out access.
REQ-012 SHALL have ports bus_req, bus_we (1 each), bus_addr (32), bus_be (4), bus_wdata (32), output: data-memory bus.
REQ-013 SHALL have ports bus_ack (1), bus_rdata (32), input: memory completion and read word.

Function
REQ-014 SHALL implement FSM states IDLE, REQ, DONE.
REQ-015 Accept: in IDLE, ex_valid and exactly one of memread/memwrite, legal funct3, aligned address -> latch op, go REQ next cycle.
REQ-016 Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; legal stores: 000 SB, 001 SH, 010 SW.
REQ-017 Misaligned: halfword with addr[0]=1, word with addr[1:0]!=0.
REQ-018 Illegal funct3, misalignment, or memread and memwrite both set -> lsu_err pulse next cycle, no bus access, no writeback, stay IDLE.
REQ-019 In REQ: bus_req=1; bus_addr={addr[31:2],2'b00}; bus_we=store; all bus outputs held stable until bus_ack.
REQ-020 bus_be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; 0 when bus_req=0.
REQ-021 bus_wdata: SB byte replicated x4, SH halfword replicated x2, SW unchanged.
REQ-022 bus_ack sampled in REQ captures bus_rdata; go DONE next cycle, bus_req drops the same edge.
REQ-023 DONE: for loads wb_valid=1 one cycle with wb_rd and lane-extracted, sign/zero-extended wb_rdata; for stores wb_valid stays 0; return IDLE next cycle.
REQ-024 lsu_stall = 1 in REQ, in IDLE when accepting, and 0 in DONE and otherwise; minimum latency accept->wb_valid 2 cycles plus ack wait.
REQ-025 Wait counter counts cycles in REQ; reaching MAX_WAIT without ack -> drop bus_req, lsu_err pulse, IDLE, no writeback.
REQ-026 bus_ack outside REQ SHALL be ignored.
REQ-027 Loads to rd=0 SHALL perform the bus access and writeback normally.
REQ-028 New ex_valid during REQ/DONE SHALL be ignored (held by lsu_stall).

Reset
REQ-029 While rst_n=1 at a clock edge: state IDLE, counter 0, bus_req, bus_we, bus_be, bus_addr, bus_wdata, wb_valid, wb_rd, wb_rdata, lsu_err, lsu_stall all 0.
REQ-030 Reset mid-REQ SHALL drop bus_req on that edge, discard the op, produce no writeback and no lsu_err.

Structure
REQ-031 Package lsu_pkg SHALL hold the FSM state enum, funct3 constants and byte-enable constants.
REQ-032 Combinational sub-module lsu_align SHALL do store lane replication/byte enables and load extract/extend; FSM and counter stay in load_store_unit.

Verification
REQ-033 LW addr 0x100, ack after 3 cycles, rdata 0xDEADBEEF -> bus_addr 0x100, be 1111, wb_valid with wb_rdata 0xDEADBEEF, stall high throughout until DONE.
REQ-034 LB addr 0x103, rdata 0x80FF_0000 -> be 1000, wb_rdata 0xFFFFFF80; same with LBU -> 0x00000080.
REQ-035 SH addr 0x202, wdata 0x1234ABCD -> bus_we 1, be 1100, bus_wdata 0xABCDABCD, wb_valid never asserts.
REQ-036 LW addr 0x101 -> lsu_err one pulse, bus_req never asserts, no stall beyond acceptance cycle.
REQ-037 LW with bus_ack held 0, MAX_WAIT=16 -> bus_req high exactly 16 cycles, then lsu_err pulse, IDLE.
REQ-038 rst_n=1 on 2nd cycle of REQ -> bus_req 0 after that edge, no wb_valid, no lsu_err; next op completes normally.
